// File: rtl/pc_ctrl.sv
// Registered program-counter unit: resolves JALR/JAL/branch/sequential targets,
// redirects traps and misaligned targets, and predicts returns with a small circular RAS.
module pc_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              ALIGN_BITS   = 2,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step,
  input  logic            stall,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            trap_req,
  input  logic            trap_ret,
  input  logic            link_push,
  input  logic            link_pop,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] epc,
  output logic            trap,
  output logic            misaligned,
  output logic [XLEN-1:0] bad_target,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid,
  output logic            ras_miss
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    SRC_JALR = 2'b00,
    SRC_JAL  = 2'b01,
    SRC_BR   = 2'b10,
    SRC_SEQ  = 2'b11
  } src_e;

  logic [XLEN-1:0]  pc_q, pc_d, epc_q, epc_d, bad_q, bad_d;
  logic             trap_q, trap_d, mis_q, mis_d, miss_q, miss_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];

  logic             ras_we;
  logic [PTR_W-1:0] ras_wptr;
  logic [XLEN-1:0]  seq_tgt, jalr_tgt, rel_tgt, target;
  logic             taken, chk, mis_tgt, upd, ras_nonempty;

  assign seq_tgt      = pc_q + XLEN'(4);
  assign jalr_tgt     = (rs1 + imm) & JALR_MASK;
  assign rel_tgt      = pc_q + imm;
  assign taken        = (alu_result == XLEN'(1));
  assign upd          = step & ~stall;
  assign ras_nonempty = (cnt_q != '0);

  always_comb begin
    target = seq_tgt;
    chk    = 1'b0;
    unique case (src_e'(pc_src))
      SRC_JALR: begin target = jalr_tgt; chk = 1'b1; end
      SRC_JAL:  begin target = rel_tgt;  chk = 1'b1; end
      SRC_BR: begin
        if (taken) begin
          target = rel_tgt;
          chk    = 1'b1;
        end
      end
      SRC_SEQ:  target = seq_tgt;
    endcase
  end

  // Only control-transfer targets that are actually taken are alignment-checked
  assign mis_tgt = chk && (target[ALIGN_BITS-1:0] != '0);

  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    bad_d    = bad_q;
    trap_d   = 1'b0;
    mis_d    = 1'b0;
    miss_d   = 1'b0;
    top_d    = top_q;
    cnt_d    = cnt_q;
    ras_we   = 1'b0;
    ras_wptr = top_q;
    if (upd) begin
      if (trap_req) begin
        epc_d  = pc_q;
        pc_d   = TRAP_VECTOR;
        trap_d = 1'b1;
      end else if (mis_tgt) begin
        epc_d  = pc_q;
        bad_d  = target;
        pc_d   = TRAP_VECTOR;
        trap_d = 1'b1;
        mis_d  = 1'b1;
      end else if (trap_ret) begin
        pc_d = epc_q;
      end else begin
        pc_d = target;
        if (link_push && link_pop) begin
          // Coroutine swap: replace top in place, prediction still checked against old top
          ras_we = 1'b1;
          miss_d = ras_nonempty && (ras_q[top_q] != jalr_tgt);
        end else if (link_push) begin
          ras_we   = 1'b1;
          ras_wptr = top_q + PTR_W'(1);
          top_d    = top_q + PTR_W'(1);
          if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
        end else if (link_pop && ras_nonempty) begin
          miss_d = (ras_q[top_q] != jalr_tgt);
          top_d  = top_q - PTR_W'(1);
          cnt_d  = cnt_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_VECTOR;
      epc_q  <= '0;
      bad_q  <= '0;
      trap_q <= 1'b0;
      mis_q  <= 1'b0;
      miss_q <= 1'b0;
      top_q  <= '0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      bad_q  <= bad_d;
      trap_q <= trap_d;
      mis_q  <= mis_d;
      miss_q <= miss_d;
      top_q  <= top_d;
      cnt_q  <= cnt_d;
    end
  end

  // RAS storage is never cleared; the count alone decides which entries are live
  always_ff @(posedge clk) begin
    if (ras_we && !rst) ras_q[ras_wptr] <= seq_tgt;
  end

  assign pc         = pc_q;
  assign pc_plus4   = seq_tgt;
  assign epc        = epc_q;
  assign trap       = trap_q;
  assign misaligned = mis_q;
  assign bad_target = bad_q;
  assign ras_top    = ras_nonempty ? ras_q[top_q] : '0;
  assign ras_valid  = ras_nonempty;
  assign ras_miss   = miss_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl with hand-computed expected values.
module tb_pc_ctrl;
  logic        clk = 1'b0;
  logic        rst, step, stall;
  logic [1:0]  pc_src;
  logic [31:0] rs1, imm, alu_result;
  logic        trap_req, trap_ret, link_push, link_pop;
  logic [31:0] pc, pc_plus4, epc, bad_target, ras_top;
  logic        trap, misaligned, ras_valid, ras_miss;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .clk(clk), .rst(rst), .step(step), .stall(stall), .pc_src(pc_src),
    .rs1(rs1), .imm(imm), .alu_result(alu_result), .trap_req(trap_req),
    .trap_ret(trap_ret), .link_push(link_push), .link_pop(link_pop),
    .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .trap(trap), .misaligned(misaligned),
    .bad_target(bad_target), .ras_top(ras_top), .ras_valid(ras_valid), .ras_miss(ras_miss)
  );

  task automatic upd(input logic [1:0] src, input logic [31:0] r, input logic [31:0] i,
                     input logic [31:0] a, input logic tq, input logic tr,
                     input logic pu, input logic po);
    pc_src = src; rs1 = r; imm = i; alu_result = a;
    trap_req = tq; trap_ret = tr; link_push = pu; link_pop = po; step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0; trap_req = 1'b0; trap_ret = 1'b0; link_push = 1'b0; link_pop = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; step = 1'b1; pc_src = 2'b11;
    @(posedge clk); #1;
    rst = 1'b0; step = 1'b0;
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    n_cmp++; if (pc_plus4 !== 32'h4) begin n_err++; $display("FAIL reset_pc4 got %h want %h", pc_plus4, 32'h4); end
    n_cmp++; if (epc !== 32'h0 || bad_target !== 32'h0) begin n_err++; $display("FAIL reset_epc_bad got %h/%h want 0/0", epc, bad_target); end
    n_cmp++; if ({trap, misaligned, ras_miss, ras_valid} !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b want 0000", {trap, misaligned, ras_miss, ras_valid}); end
    n_cmp++; if (ras_top !== 32'h0) begin n_err++; $display("FAIL reset_ras_top got %h want 0", ras_top); end
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 3; k++) begin
      upd(2'b11, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (pc !== 32'(4 * k)) begin n_err++; $display("FAIL seq_pc%0d got %h want %h", k, pc, 32'(4 * k)); end
    end
    stall = 1'b1; step = 1'b1; pc_src = 2'b11;
    @(posedge clk); #1;
    stall = 1'b0; step = 1'b0;
    n_cmp++; if (pc !== 32'hC) begin n_err++; $display("FAIL stall_hold got %h want %h", pc, 32'hC); end
    n_cmp++; if (pc_plus4 !== 32'h10) begin n_err++; $display("FAIL stall_pc4 got %h want %h", pc_plus4, 32'h10); end
  endtask

  task automatic test_branch();
    upd(2'b00, 32'h10, 0, 0, 0, 0, 0, 0);
    upd(2'b10, 0, 32'h20, 32'h1, 0, 0, 0, 0);
    n_cmp++; if (pc !== 32'h30) begin n_err++; $display("FAIL br_taken got %h want %h", pc, 32'h30); end
    upd(2'b00, 32'h10, 0, 0, 0, 0, 0, 0);
    upd(2'b10, 0, 32'h20, 32'h2, 0, 0, 0, 0);
    n_cmp++; if (pc !== 32'h14 || trap !== 1'b0) begin n_err++; $display("FAIL br_not_taken got %h/%b want 00000014/0", pc, trap); end
    upd(2'b10, 0, 32'h22, 32'h8000_0001, 0, 0, 0, 0);
    n_cmp++; if (pc !== 32'h18 || trap !== 1'b0) begin n_err++; $display("FAIL br_wide_pred got %h/%b want 00000018/0", pc, trap); end
    upd(2'b00, 32'h201, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (pc !== 32'h200 || trap !== 1'b0) begin n_err++; $display("FAIL jalr_lsb got %h/%b want 00000200/0", pc, trap); end
  endtask

  task automatic test_misaligned();
    upd(2'b00, 32'h40, 0, 0, 0, 0, 0, 0);
    upd(2'b00, 32'h103, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL mis_pc got %h want %h", pc, 32'h100); end
    n_cmp++; if (trap !== 1'b1 || misaligned !== 1'b1) begin n_err++; $display("FAIL mis_pulse got %b%b want 11", trap, misaligned); end
    n_cmp++; if (bad_target !== 32'h102) begin n_err++; $display("FAIL mis_bad got %h want %h", bad_target, 32'h102); end
    n_cmp++; if (epc !== 32'h40) begin n_err++; $display("FAIL mis_epc got %h want %h", epc, 32'h40); end
    idle();
    n_cmp++; if (trap !== 1'b0 || misaligned !== 1'b0 || pc !== 32'h100) begin n_err++; $display("FAIL mis_one_cycle got %b%b/%h want 00/00000100", trap, misaligned, pc); end
    upd(2'b11, 0, 0, 0, 0, 1, 0, 0);
    n_cmp++; if (pc !== 32'h40 || trap !== 1'b0) begin n_err++; $display("FAIL trap_ret got %h/%b want 00000040/0", pc, trap); end
  endtask

  task automatic test_ras_fill();
    logic [31:0] ret_tgt [4];
    ret_tgt = '{32'h44, 32'h34, 32'h24, 32'h14};
    upd(2'b00, 32'h0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) upd(2'b01, 0, 32'h10, 0, 0, 0, 1, 0);
    n_cmp++; if (ras_top !== 32'h44 || ras_valid !== 1'b1 || pc !== 32'h50) begin n_err++; $display("FAIL ras_full got %h/%b/%h want 00000044/1/00000050", ras_top, ras_valid, pc); end
    for (int k = 0; k < 4; k++) begin
      upd(2'b00, ret_tgt[k], 0, 0, 0, 0, 0, 1);
      n_cmp++; if (ras_miss !== 1'b0 || pc !== ret_tgt[k]) begin n_err++; $display("FAIL ras_ret%0d got %b/%h want 0/%h", k, ras_miss, pc, ret_tgt[k]); end
    end
    n_cmp++; if (ras_valid !== 1'b0 || ras_top !== 32'h0) begin n_err++; $display("FAIL ras_drained got %b/%h want 0/0", ras_valid, ras_top); end
    upd(2'b00, 32'h200, 0, 0, 0, 0, 0, 1);
    n_cmp++; if (ras_miss !== 1'b0 || ras_valid !== 1'b0 || pc !== 32'h200) begin n_err++; $display("FAIL ras_underflow got %b/%b/%h want 0/0/00000200", ras_miss, ras_valid, pc); end
  endtask

  task automatic test_ras_miss();
    upd(2'b00, 32'h40, 0, 0, 0, 0, 0, 0);
    upd(2'b01, 0, 32'h10, 0, 0, 0, 1, 0);
    upd(2'b00, 32'h80, 0, 0, 0, 0, 0, 1);
    n_cmp++; if (ras_miss !== 1'b1 || pc !== 32'h80) begin n_err++; $display("FAIL ras_miss got %b/%h want 1/00000080", ras_miss, pc); end
    idle();
    n_cmp++; if (ras_miss !== 1'b0) begin n_err++; $display("FAIL ras_miss_pulse got %b want 0", ras_miss); end
    upd(2'b00, 32'h40, 0, 0, 0, 0, 0, 0);
    upd(2'b01, 0, 32'h10, 0, 0, 0, 1, 0);
    upd(2'b00, 32'h44, 0, 0, 0, 0, 1, 1);
    n_cmp++; if (ras_top !== 32'h54 || ras_valid !== 1'b1 || ras_miss !== 1'b0) begin n_err++; $display("FAIL coroutine got %h/%b/%b want 00000054/1/0", ras_top, ras_valid, ras_miss); end
    upd(2'b00, 32'h54, 0, 0, 0, 0, 0, 1);
    n_cmp++; if (ras_valid !== 1'b0 || ras_miss !== 1'b0) begin n_err++; $display("FAIL coroutine_count got %b/%b want 0/0", ras_valid, ras_miss); end
  endtask

  task automatic test_back_to_back();
    upd(2'b00, 32'h40, 0, 0, 0, 0, 0, 0);
    upd(2'b01, 0, 32'h10, 0, 0, 0, 1, 0);
    upd(2'b01, 0, 32'h2, 0, 1, 1, 1, 0);
    n_cmp++; if (pc !== 32'h100 || trap !== 1'b1 || misaligned !== 1'b0) begin n_err++; $display("FAIL trap_prio got %h/%b%b want 00000100/10", pc, trap, misaligned); end
    n_cmp++; if (epc !== 32'h50 || bad_target !== 32'h102) begin n_err++; $display("FAIL trap_prio_regs got %h/%h want 00000050/00000102", epc, bad_target); end
    n_cmp++; if (ras_top !== 32'h44 || ras_valid !== 1'b1) begin n_err++; $display("FAIL trap_ras_hold got %h/%b want 00000044/1", ras_top, ras_valid); end
    rst = 1'b1; step = 1'b1; pc_src = 2'b11;
    @(posedge clk); #1;
    rst = 1'b0; step = 1'b0;
    n_cmp++; if (pc !== 32'h0 || ras_valid !== 1'b0 || epc !== 32'h0 || trap !== 1'b0) begin n_err++; $display("FAIL rst_upd got %h/%b/%h/%b want 0/0/0/0", pc, ras_valid, epc, trap); end
  endtask

  initial begin
    rst = 1'b0; step = 1'b0; stall = 1'b0; pc_src = 2'b11;
    rs1 = '0; imm = '0; alu_result = '0;
    trap_req = 1'b0; trap_ret = 1'b0; link_push = 1'b0; link_pop = 1'b0;
    #2;
    test_reset();
    test_sequential();
    test_branch();
    test_misaligned();
    test_ras_fill();
    test_ras_miss();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Parametrised, registered program-counter unit for the RISC-V core. It replaces the purely combinational next-PC selector.
- Holds the architectural PC and advances it once per retired instruction. Resolves JALR, JAL, branch and sequential targets.
- Detects misaligned control-transfer targets and redirects them to a trap vector with a captured EPC. Handles trap entry and return.
- Contains a small circular return-address stack (RAS) that predicts JALR returns and flags mispredictions to the fetch/decode logic.

Parameters:
XLEN, 32, datapath and PC width
RESET_VECTOR, 32'h0000_0000, PC value after reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry
ALIGN_BITS, 2, low target bits that must be zero (2 = 4-byte, 1 = compressed-capable)
RAS_DEPTH, 4, RAS entries (power of two, >= 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
step  in  1  current instruction retires this cycle; PC updates on this edge
stall  in  1  blocks update; when high, step is ignored
pc_src  in  2  00 JALR, 01 JAL, 10 branch, 11 sequential
rs1  in  XLEN  JALR base
imm  in  XLEN  sign-extended immediate
alu_result  in  XLEN  branch predicate; taken iff == 1
trap_req  in  1  external trap (illegal instr, ecall)
trap_ret  in  1  return from trap (mret)
link_push  in  1  instruction is a call (rd is x1/x5)
link_pop  in  1  instruction is a return (JALR, rs1 is x1/x5, rd not link)
pc  out  XLEN  current PC
pc_plus4  out  XLEN  pc + 4, combinational
epc  out  XLEN  saved exception PC
trap  out  1  one-cycle pulse after a trap-entry update
misaligned  out  1  one-cycle pulse; the trap was caused by target misalignment
bad_target  out  XLEN  offending target from the last misalignment
ras_top  out  XLEN  predicted return address
ras_valid  out  1  RAS non-empty
ras_miss  out  1  one-cycle pulse; a popped prediction differed from the real JALR target

Behaviour:
- Reset (synchronous, highest priority, aborts any pending update):
  - pc = RESET_VECTOR.
  - epc, bad_target = 0.
  - trap, misaligned, ras_miss = 0.
  - RAS count = 0, ras_valid = 0, ras_top = 0. RAS entries need not be cleared.
- Update condition: upd = step & ~stall & ~rst. With no upd, all state holds and all pulse outputs are 0 on the next cycle.
- Target computation (combinational, mod 2^XLEN, wrap-around silent):
  - JALR: (rs1 + imm) & ~1.
  - JAL and branch: pc + imm.
  - Branch taken iff alu_result == 1 over the full width; otherwise pc + 4.
  - Sequential: pc + 4.
- Misalignment: a taken JALR, JAL or branch target with target[ALIGN_BITS-1:0] != 0. The sequential path and not-taken branches are never checked.
- Priority on upd, highest first:
  1. trap_req: epc <= pc, pc <= TRAP_VECTOR, trap pulses. No RAS change.
  2. Misaligned target: epc <= pc, bad_target <= target, pc <= TRAP_VECTOR, trap and misaligned pulse. No RAS change.
  3. trap_ret: pc <= epc. No RAS change. Same-cycle trap_req takes precedence.
  4. Normal: pc <= selected target, then apply the RAS rules.
- Latency: pc reflects the new value in the cycle after the upd edge. Pulses are asserted for exactly that one cycle.
- RAS (circular buffer with top pointer and saturating count 0..RAS_DEPTH):
  - Push (link_push only): write pc + 4 at top+1, advance top, count = min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten.
  - Pop (link_pop only):
    - If count > 0: compare the entry against the real JALR target, pulse ras_miss on mismatch, retreat top, decrement count.
    - If count == 0: nothing changes and ras_miss = 0.
  - Push and pop together (coroutine): the top entry is replaced by pc + 4. Count and pointer are unchanged. ras_miss is still evaluated against the old top.
  - ras_top = entry at top when count > 0, else 0. ras_valid = (count != 0).

Test Plan:
1. Reset, then 3 upd with pc_src=11 -> pc 0x0, 0x4, 0x8, 0xC. stall=1 with step=1 -> pc holds 0xC.
2. pc=0x10, branch, imm=0x20: alu_result=1 -> pc=0x30. alu_result=2 -> pc=0x14 (not taken, no trap).
3. JALR rs1=0x103, imm=0 -> pc=0x102. With ALIGN_BITS=2: trap=1, misaligned=1, bad_target=0x102, epc=old pc, pc=0x100. Then trap_ret -> pc=old epc.
4. RAS_DEPTH=4: five calls from pc 0x0, 0x10, 0x20, 0x30, 0x40 -> count saturates, ras_top=0x44. Four returns to the correct targets (0x44, 0x34, 0x24, 0x14) -> no ras_miss, ras_valid=0 afterwards. A fifth return -> ras_miss=0, state unchanged.
5. Call from 0x40 then return with JALR target 0x80 -> ras_miss=1 for one cycle. Simultaneous push and pop at pc=0x50 -> ras_top=0x54, count unchanged.
6. trap_req together with a misaligned JAL and with trap_ret -> pc=TRAP_VECTOR, misaligned=0. rst asserted in the same cycle as upd -> pc=RESET_VECTOR and the RAS is empty.
